// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - shared timing defaults, colour constants and colour-bar lookup
package lcd_timing_pkg;

  localparam int COORD_W = 11;

  // Default 800x480 panel timing
  localparam logic [COORD_W-1:0] DEF_H_SYNC  = 11'd128;
  localparam logic [COORD_W-1:0] DEF_H_BACK  = 11'd88;
  localparam logic [COORD_W-1:0] DEF_H_DISP  = 11'd800;
  localparam logic [COORD_W-1:0] DEF_H_FRONT = 11'd40;
  localparam logic [COORD_W-1:0] DEF_V_SYNC  = 11'd2;
  localparam logic [COORD_W-1:0] DEF_V_BACK  = 11'd33;
  localparam logic [COORD_W-1:0] DEF_V_DISP  = 11'd480;
  localparam logic [COORD_W-1:0] DEF_V_FRONT = 11'd10;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  // Colour bars, index 0 is the leftmost bar
  localparam logic [7:0][23:0] BAR_TABLE = {
    BLACK, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, WHITE
  };

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// rtl/lcd_sync_counter.sv - enabled modulo-TOTAL counter with a wrap pulse
module lcd_sync_counter
  import lcd_timing_pkg::*;
#(
  parameter int            W     = COORD_W,
  parameter logic [W-1:0]  TOTAL = W'(1056)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  // Wrap fires on the last count of an enabled cycle
  assign wrap = en && (cnt == TOTAL - 1'b1);

  // Count 0..TOTAL-1 while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_timing_driver.sv
// rtl/lcd_timing_driver.sv - RGB LCD timing master; LCD_TEST_PATTERN_EN selects colour bars
module lcd_timing_driver
  import lcd_timing_pkg::*;
#(
  parameter logic [COORD_W-1:0] H_SYNC   = DEF_H_SYNC,
  parameter logic [COORD_W-1:0] H_BACK   = DEF_H_BACK,
  parameter logic [COORD_W-1:0] H_DISP   = DEF_H_DISP,
  parameter logic [COORD_W-1:0] H_FRONT  = DEF_H_FRONT,
  parameter logic [COORD_W-1:0] V_SYNC   = DEF_V_SYNC,
  parameter logic [COORD_W-1:0] V_BACK   = DEF_V_BACK,
  parameter logic [COORD_W-1:0] V_DISP   = DEF_V_DISP,
  parameter logic [COORD_W-1:0] V_FRONT  = DEF_V_FRONT,
  parameter logic               SYNC_POL = 1'b0
) (
  input  logic               lcd_pclk,
  input  logic               rst_n,
  input  logic [23:0]        pixel_data,
  output logic [COORD_W-1:0] pixel_xpos,
  output logic [COORD_W-1:0] pixel_ypos,
  output logic [COORD_W-1:0] h_disp,
  output logic [COORD_W-1:0] v_disp,
  output logic               data_req,
  output logic               frame_start,
  output logic               lcd_de,
  output logic               lcd_hs,
  output logic               lcd_vs,
  output logic               lcd_bl,
  output logic [23:0]        lcd_rgb
);

  localparam logic [COORD_W-1:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [COORD_W-1:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [COORD_W-1:0] HS      = H_SYNC + H_BACK;
  localparam logic [COORD_W-1:0] VS      = V_SYNC + V_BACK;
  // Coordinates lead the panel by one cycle, so the request window starts at HS-1
  localparam logic [COORD_W-1:0] X_START = HS - 11'd1;
  localparam logic [COORD_W-1:0] X_END   = HS + H_DISP - 11'd1;
  localparam logic [COORD_W-1:0] Y_END   = VS + V_DISP;

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_wrap;
  logic               v_wrap;
  logic               active_line;
  logic               at_origin;

  lcd_sync_counter #(.W(COORD_W), .TOTAL(H_TOTAL)) u_h_counter (
    .clk   (lcd_pclk),
    .rst_n (rst_n),
    .en    (1'b1),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  lcd_sync_counter #(.W(COORD_W), .TOTAL(V_TOTAL)) u_v_counter (
    .clk   (lcd_pclk),
    .rst_n (rst_n),
    .en    (h_wrap),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  assign h_disp = H_DISP;
  assign v_disp = V_DISP;

  // Decode the request window and next-pixel coordinates from the counters
  always_comb begin
    active_line = (v_cnt >= VS) && (v_cnt < Y_END);
    data_req    = active_line && (h_cnt >= X_START) && (h_cnt < X_END);
    pixel_xpos  = data_req ? h_cnt - X_START : '0;
    pixel_ypos  = active_line ? v_cnt - VS : '0;
  end

  // Panel controls; at_origin tracks h_cnt==0 && v_cnt==0 so frame_start follows it by a cycle
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_de      <= 1'b0;
      lcd_hs      <= ~SYNC_POL;
      lcd_vs      <= ~SYNC_POL;
      lcd_bl      <= 1'b0;
      frame_start <= 1'b0;
      at_origin   <= 1'b1;
    end else begin
      lcd_de      <= data_req;
      lcd_hs      <= (h_cnt < H_SYNC) ? SYNC_POL : ~SYNC_POL;
      lcd_vs      <= (v_cnt < V_SYNC) ? SYNC_POL : ~SYNC_POL;
      lcd_bl      <= 1'b1;
      frame_start <= at_origin;
      at_origin   <= h_wrap && v_wrap;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  localparam logic [COORD_W-1:0] BAR_W = ((H_DISP >> 3) == 11'd0) ? 11'd1 : (H_DISP >> 3);

  logic [COORD_W-1:0] xpos_q;
  logic [COORD_W-1:0] bar_idx;

  // Keep the column aligned with lcd_de
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      xpos_q <= '0;
    end else begin
      xpos_q <= pixel_xpos;
    end
  end

  // Pick the bar colour for the current column, blanked outside lcd_de
  always_comb begin
    bar_idx = xpos_q / BAR_W;
    lcd_rgb = '0;
    if (lcd_de) begin
      lcd_rgb = bar_colour((bar_idx > 11'd7) ? 3'd7 : bar_idx[2:0]);
    end
  end
`else
  assign lcd_rgb = lcd_de ? pixel_data : 24'h0;
`endif

endmodule

// File: tb/tb_lcd_timing_driver.sv
// tb/tb_lcd_timing_driver.sv - scoreboard bench for lcd_timing_driver on a 15x8 timing
module tb_lcd_timing_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pixel_data = 24'h0;

  logic [10:0] xpos, ypos, hdisp, vdisp;
  logic        dr, fs, de, hs, vs, bl;
  logic [23:0] rgb;
  logic [10:0] xpos_b, ypos_b, hdisp_b, vdisp_b;
  logic        dr_b, fs_b, de_b, hs_b, vs_b, bl_b;
  logic [23:0] rgb_b;

  lcd_timing_driver #(
    .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2),
    .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1),
    .SYNC_POL(1'b0)
  ) dut (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_data(pixel_data),
    .pixel_xpos(xpos), .pixel_ypos(ypos), .h_disp(hdisp), .v_disp(vdisp),
    .data_req(dr), .frame_start(fs), .lcd_de(de), .lcd_hs(hs), .lcd_vs(vs),
    .lcd_bl(bl), .lcd_rgb(rgb)
  );

  lcd_timing_driver #(
    .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2),
    .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1),
    .SYNC_POL(1'b1)
  ) dut_pol (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_data(pixel_data),
    .pixel_xpos(xpos_b), .pixel_ypos(ypos_b), .h_disp(hdisp_b), .v_disp(vdisp_b),
    .data_req(dr_b), .frame_start(fs_b), .lcd_de(de_b), .lcd_hs(hs_b), .lcd_vs(vs_b),
    .lcd_bl(bl_b), .lcd_rgb(rgb_b)
  );

  always #5 clk = ~clk;

  // Pixel generator: registers its coordinates as the returned pixel
  always @(posedge clk) pixel_data <= {2'b0, ypos, xpos};

  typedef struct {
    int          k;
    int          ph;
    logic        dr;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs, de, hs, vs, bl, hs2, vs2;
    logic [23:0] rgb;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s k=%0d got=%0h want=%0h", nm, k, act, want);
    end
  endtask

  // Expected outputs k cycles after reset release (k=0: counters at origin, registers at reset)
  function automatic exp_t calc(input int k, input int ph);
    exp_t        e;
    int          h, v, hp, vp;
    logic        drp;
    logic [10:0] xp, yp;
    h = k % 15;
    v = (k / 15) % 8;
    e.k   = k;
    e.ph  = ph;
    e.dr  = (v >= 3 && v < 7 && h >= 4 && h < 12);
    e.x   = e.dr ? 11'(h - 4) : 11'd0;
    e.y   = (v >= 3 && v < 7) ? 11'(v - 3) : 11'd0;
    e.fs  = 1'b0; e.de = 1'b0; e.bl = 1'b0; e.rgb = 24'h0;
    e.hs  = 1'b1; e.vs = 1'b1; e.hs2 = 1'b0; e.vs2 = 1'b0;
    if (k > 0) begin
      hp  = (k - 1) % 15;
      vp  = ((k - 1) / 15) % 8;
      drp = (vp >= 3 && vp < 7 && hp >= 4 && hp < 12);
      xp  = drp ? 11'(hp - 4) : 11'd0;
      yp  = (vp >= 3 && vp < 7) ? 11'(vp - 3) : 11'd0;
      e.de  = drp;
      e.fs  = (hp == 0 && vp == 0);
      e.bl  = 1'b1;
      e.hs  = !(hp < 2);
      e.vs  = !(vp < 1);
      e.hs2 = (hp < 2);
      e.vs2 = (vp < 1);
`ifdef LCD_TEST_PATTERN_EN
      e.rgb = drp ? bars[(xp > 11'd7) ? 7 : int'(xp)] : 24'h0;
`else
      e.rgb = drp ? {2'b0, yp, xp} : 24'h0;
`endif
    end
    return e;
  endfunction

  int fs_cnt [3] = '{0, 0, 0};
  int hs_low = 0, vs_low = 0, hs2_high = 0, vs2_high = 0;
  int first_de = -1, last_fs = -1;

  // Monitor: compare each cycle's outputs against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("data_req", e.k, 32'(dr), 32'(e.dr));
      chk("xpos", e.k, 32'(xpos), 32'(e.x));
      chk("ypos", e.k, 32'(ypos), 32'(e.y));
      chk("frame_start", e.k, 32'(fs), 32'(e.fs));
      chk("lcd_de", e.k, 32'(de), 32'(e.de));
      chk("lcd_hs", e.k, 32'(hs), 32'(e.hs));
      chk("lcd_vs", e.k, 32'(vs), 32'(e.vs));
      chk("lcd_bl", e.k, 32'(bl), 32'(e.bl));
      chk("lcd_rgb", e.k, 32'(rgb), 32'(e.rgb));
      chk("h_disp", e.k, 32'(hdisp), 32'd8);
      chk("v_disp", e.k, 32'(vdisp), 32'd4);
      chk("pol_hs", e.k, 32'(hs_b), 32'(e.hs2));
      chk("pol_vs", e.k, 32'(vs_b), 32'(e.vs2));
      chk("pol_de", e.k, 32'(de_b), 32'(e.de));
      chk("pol_rgb", e.k, 32'(rgb_b), 32'(e.rgb));
      if (e.ph == 0 && e.k == 48) chk("dr_before_first", e.k, 32'(dr), 32'd0);
      if (e.ph == 0 && e.k == 49) begin
        chk("dr_first", e.k, 32'(dr), 32'd1);
        chk("xpos_first", e.k, 32'(xpos), 32'd0);
        chk("ypos_first", e.k, 32'(ypos), 32'd0);
      end
`ifdef LCD_TEST_PATTERN_EN
      if (e.ph == 0 && e.k >= 50 && e.k <= 57) chk("bar", e.k, 32'(rgb), 32'(bars[e.k - 50]));
`else
      if (e.ph == 0 && e.k == 87) chk("rgb_l2_c7", e.k, 32'(rgb), 32'h001007);
`endif
      if (e.ph == 1 && e.k == 1) chk("fs_after_reset", e.k, 32'(fs), 32'd1);
      if (e.ph == 0 && e.k >= 1 && e.k <= 15) begin
        if (!hs) hs_low++;
        if (hs_b) hs2_high++;
      end
      if (e.ph == 0 && e.k >= 1 && e.k <= 120) begin
        if (!vs) vs_low++;
        if (vs_b) vs2_high++;
      end
      if (fs) fs_cnt[e.ph]++;
      if (fs && e.ph == 0) begin
        if (last_fs >= 0) chk("fs_period", e.k, 32'(e.k - last_fs), 32'd120);
        last_fs = e.k;
      end
      if (e.ph == 1 && de && first_de < 0) first_de = e.k;
    end
  end

  // Stimulus: reset, two frames less a bit, mid-line reset at h=9 v=5, then restart
  initial begin
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      sb.push_back(calc(0, 2));
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 204; k++) begin
      @(posedge clk); #1;
      if (k == 204) begin
        rst_n = 1'b0;
        #1;
        sb.push_back(calc(0, 2));
      end else begin
        sb.push_back(calc(k, 0));
      end
    end
    repeat (2) begin
      @(posedge clk); #1;
      sb.push_back(calc(0, 2));
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(posedge clk); #1;
      sb.push_back(calc(k, 1));
    end
    @(negedge clk);
    @(posedge clk); #1;
    chk("sb_drained", 0, 32'(sb.size()), 32'd0);
    chk("hs_low_per_line", 0, 32'(hs_low), 32'd2);
    chk("vs_low_per_frame", 0, 32'(vs_low), 32'd15);
    chk("pol_hs_high_per_line", 0, 32'(hs2_high), 32'd2);
    chk("pol_vs_high_per_frame", 0, 32'(vs2_high), 32'd15);
    chk("fs_count_run0", 0, 32'(fs_cnt[0]), 32'd2);
    chk("fs_count_run1", 0, 32'(fs_cnt[1]), 32'd2);
    chk("fs_count_reset", 0, 32'(fs_cnt[2]), 32'd0);
    chk("first_de_after_reset", 0, 32'(first_de), 32'd50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
